// File: rtl/bus_dma_if.sv
// Word-addressed system bus as seen by a bus master: address, byte write enables,
// write data out and registered read data back.
interface bus_dma_if;
   logic [29:0] bus_addr;
   logic [31:0] bus_data_r;
   logic [31:0] bus_data_w;
   logic [3:0]  bus_mask_w;

   modport master (
      output bus_addr,
      output bus_data_w,
      output bus_mask_w,
      input  bus_data_r
   );

   modport slave (
      input  bus_addr,
      input  bus_data_w,
      input  bus_mask_w,
      output bus_data_r
   );
endinterface

// File: rtl/bus_dma.sv
// Block copy / fill engine on the word-address bus. Copy alternates READ and WRITE
// cycles (2 cycles/word); fill issues a write every cycle.
module bus_dma #(
   parameter int LEN_BITS = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic                fill_mode,
   input  logic [29:0]         src_addr,
   input  logic [29:0]         dst_addr,
   input  logic [LEN_BITS-1:0] count,
   input  logic [31:0]         fill_data,
   output logic                busy,
   output logic                done,
   output logic [31:0]         sum,
   bus_dma_if.master           bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [29:0]         r_src;
   logic [29:0]         r_dst;
   logic [LEN_BITS-1:0] r_rem;
   logic                r_fill;
   logic [31:0]         r_fill_data;
   logic [31:0]         r_sum;
   logic                r_done;
   logic                w_accept;
   logic                w_last;
   logic [31:0]         w_wdata;

   assign w_accept = (r_state == S_IDLE) && start;
   assign w_last   = (r_state == S_WRITE) && (r_rem == LEN_BITS'(1));

   // Read data flows straight through to the write port in a copy WRITE cycle.
   assign w_wdata = (r_state != S_WRITE) ? 32'h0 :
                    (r_fill ? r_fill_data : bus.bus_data_r);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      bus.bus_addr   = 30'h0;
      bus.bus_mask_w = 4'h0;
      bus.bus_data_w = 32'h0;
      case (r_state)
         S_IDLE: begin
            if (start && (count != '0)) begin
               w_state_nxt = fill_mode ? S_WRITE : S_READ;
            end
         end
         S_READ: begin
            bus.bus_addr = r_src;
            w_state_nxt  = S_WRITE;
         end
         S_WRITE: begin
            bus.bus_addr   = r_dst;
            bus.bus_mask_w = 4'hF;
            bus.bus_data_w = w_wdata;
            if (w_last) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = r_fill ? S_WRITE : S_READ;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_src       <= 30'h0;
         r_dst       <= 30'h0;
         r_rem       <= '0;
         r_fill      <= 1'b0;
         r_fill_data <= 32'h0;
         r_sum       <= 32'h0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_sum <= 32'h0;
            if (count == '0) begin
               r_done <= 1'b1;
            end else begin
               r_src       <= src_addr;
               r_dst       <= dst_addr;
               r_rem       <= count;
               r_fill      <= fill_mode;
               r_fill_data <= fill_data;
            end
         end
         if (r_state == S_WRITE) begin
            r_sum <= r_sum + w_wdata;
            r_src <= r_src + 30'd1;
            r_dst <= r_dst + 30'd1;
            r_rem <= r_rem - LEN_BITS'(1);
            if (w_last) begin
               r_done <= 1'b1;
            end
         end
      end
   end

   assign busy = (r_state != S_IDLE);
   assign done = r_done;
   assign sum  = r_sum;

endmodule

// File: tb/tb_bus_dma.sv
// Bench for bus_dma: a bus memory responder, and a word-level transfer model that
// predicts every bus access, the done cycle and the sum of each transfer.
module tb_bus_dma;
   localparam int LB = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic          fill_mode;
   logic [29:0]   src_addr;
   logic [29:0]   dst_addr;
   logic [LB-1:0] count;
   logic [31:0]   fill_data;
   logic          busy;
   logic          done;
   logic [31:0]   sum;

   bus_dma_if bus ();

   bus_dma #(.LEN_BITS(LB)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .fill_mode (fill_mode),
      .src_addr  (src_addr),
      .dst_addr  (dst_addr),
      .count     (count),
      .fill_data (fill_data),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .bus       (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          rel;
      logic [29:0] a;
      logic [31:0] d;
      logic [3:0]  m;
   } acc_t;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;

   always @(posedge clock) cyc <= cyc + 1;

   // Memory contents: words written over the bus, else preloaded words, else a pattern.
   logic [31:0] mem      [logic [29:0]];
   logic [31:0] init_mem [logic [29:0]];
   logic [31:0] ref_mem  [logic [29:0]];

   function automatic logic [31:0] init_val(input logic [29:0] a);
      if (init_mem.exists(a)) return init_mem[a];
      return {a[15:0], ~a[15:0]} ^ 32'h5A3C_9671;
   endfunction

   always @(posedge clock) begin
      bus.bus_data_r <= mem.exists(bus.bus_addr) ? mem[bus.bus_addr] : init_val(bus.bus_addr);
      if (bus.bus_mask_w != 4'h0) mem[bus.bus_addr] = bus.bus_data_w;
   end

   acc_t wq[$];
   acc_t rq[$];
   int   busy_cnt = 0;
   int   done_cnt = 0;

   always @(negedge clock) begin
      if (bus.bus_mask_w != 4'h0)
         wq.push_back('{cyc, bus.bus_addr, bus.bus_data_w, bus.bus_mask_w});
      else if (busy)
         rq.push_back('{cyc, bus.bus_addr, 32'h0, 4'h0});
      if (busy) busy_cnt = busy_cnt + 1;
      if (done) done_cnt = done_cnt + 1;
   end

   acc_t        exp_w[$];
   acc_t        exp_r[$];
   logic [31:0] exp_sum;
   int          exp_done;
   int          c0, wbase, rbase, bbase, dbase;

   function automatic logic [31:0] ref_rd(input logic [29:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   // Called at a negedge; returns one negedge later with start dropped.
   task automatic launch(input logic fm, input logic [29:0] s, input logic [29:0] d,
                         input int n, input logic [31:0] fd);
      logic [29:0] ra, wa;
      logic [31:0] dv;
      fill_mode = fm; src_addr = s; dst_addr = d; count = n[LB-1:0]; fill_data = fd;
      start = 1'b1;
      c0 = cyc; wbase = wq.size(); rbase = rq.size(); bbase = busy_cnt; dbase = done_cnt;
      exp_w.delete(); exp_r.delete(); exp_sum = 32'h0;
      for (int i = 0; i < n; i++) begin
         ra = s + 30'(i);
         wa = d + 30'(i);
         dv = fm ? fd : ref_rd(ra);
         if (!fm) exp_r.push_back('{2*i+1, ra, 32'h0, 4'h0});
         ref_mem[wa] = dv;
         exp_w.push_back('{fm ? i+1 : 2*i+2, wa, dv, 4'hF});
         exp_sum = exp_sum + dv;
      end
      exp_done = (fm ? n : 2*n) + 1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic check_xfer(input string nm, input bit settle);
      int dc, nw, nr;
      for (int k = 0; k < exp_done + 20 && done !== 1'b1; k++) @(negedge clock);
      dc = (done === 1'b1) ? cyc - c0 : -1;
      nvec++;
      if (dc !== exp_done) begin
         nerr++; $display("FAIL %s done_cycle: got %0d expected %0d", nm, dc, exp_done);
      end
      nvec++;
      if (sum !== exp_sum) begin
         nerr++; $display("FAIL %s sum: got %h expected %h", nm, sum, exp_sum);
      end
      nw = wq.size() - wbase;
      nr = rq.size() - rbase;
      nvec++;
      if (nw !== exp_w.size() || nr !== exp_r.size()) begin
         nerr++;
         $display("FAIL %s access_count: got w=%0d r=%0d expected w=%0d r=%0d",
                  nm, nw, nr, exp_w.size(), exp_r.size());
      end
      for (int i = 0; i < nw && i < exp_w.size(); i++) begin
         nvec++;
         if (wq[wbase+i].rel - c0 !== exp_w[i].rel || wq[wbase+i].a !== exp_w[i].a ||
             wq[wbase+i].d !== exp_w[i].d || wq[wbase+i].m !== exp_w[i].m) begin
            nerr++;
            $display("FAIL %s write%0d: got cyc=%0d a=%h d=%h m=%h expected cyc=%0d a=%h d=%h m=%h",
                     nm, i, wq[wbase+i].rel - c0, wq[wbase+i].a, wq[wbase+i].d, wq[wbase+i].m,
                     exp_w[i].rel, exp_w[i].a, exp_w[i].d, exp_w[i].m);
         end
      end
      for (int i = 0; i < nr && i < exp_r.size(); i++) begin
         nvec++;
         if (rq[rbase+i].rel - c0 !== exp_r[i].rel || rq[rbase+i].a !== exp_r[i].a) begin
            nerr++;
            $display("FAIL %s read%0d: got cyc=%0d a=%h expected cyc=%0d a=%h",
                     nm, i, rq[rbase+i].rel - c0, rq[rbase+i].a, exp_r[i].rel, exp_r[i].a);
         end
      end
      if (settle) begin
         @(negedge clock);
         nvec++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            nerr++; $display("FAIL %s after_done: got done=%b busy=%b expected 0 0", nm, done, busy);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; fill_mode = 1'b0; src_addr = '0; dst_addr = '0;
      count = '0; fill_data = '0;
      repeat (2) @(negedge clock);
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b expected 0", busy); end
      nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b expected 0", done); end
      nvec++; if (sum !== 32'h0) begin nerr++; $display("FAIL reset_sum: got %h expected 0", sum); end
      nvec++; if (bus.bus_addr !== 30'h0) begin nerr++; $display("FAIL reset_addr: got %h expected 0", bus.bus_addr); end
      nvec++; if (bus.bus_data_w !== 32'h0) begin nerr++; $display("FAIL reset_wdata: got %h expected 0", bus.bus_data_w); end
      nvec++; if (bus.bus_mask_w !== 4'h0) begin nerr++; $display("FAIL reset_mask: got %h expected 0", bus.bus_mask_w); end
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_copy();
      init_mem[30'h10] = 32'h11; init_mem[30'h11] = 32'h22; init_mem[30'h12] = 32'h33;
      launch(1'b0, 30'h10, 30'h20, 3, 32'h0);
      check_xfer("copy", 1'b1);
   endtask

   task automatic test_fill();
      launch(1'b1, 30'h0, 30'h100, 4, 32'hDEADBEEF);
      check_xfer("fill", 1'b1);
   endtask

   task automatic test_zero_count();
      launch(1'b0, 30'h40, 30'h300, 0, 32'h1234);
      check_xfer("zero", 1'b1);
      nvec++;
      if (busy_cnt - bbase !== 0) begin
         nerr++; $display("FAIL zero_busy: got %0d busy cycles expected 0", busy_cnt - bbase);
      end
   endtask

   task automatic test_wrap();
      launch(1'b0, 30'h3FFFFFFF, 30'h200, 2, 32'h0);
      fill_mode = 1'b1; src_addr = 30'h5; dst_addr = 30'h6; count = 16'd7; fill_data = 32'hCAFE;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check_xfer("wrap", 1'b1);
   endtask

   task automatic test_reset_mid();
      int nw;
      launch(1'b1, 30'h0, 30'h400, 4, 32'hA5A5_0F0F);
      @(negedge clock);
      #2 reset = 1'b1;
      #1;
      nvec++;
      if (bus.bus_mask_w !== 4'h0 || busy !== 1'b0) begin
         nerr++; $display("FAIL midreset_stop: got mask=%h busy=%b expected 0 0", bus.bus_mask_w, busy);
      end
      @(negedge clock);
      #1 reset = 1'b0;
      repeat (6) @(negedge clock);
      nw = wq.size() - wbase;
      nvec++;
      if (nw !== 2) begin nerr++; $display("FAIL midreset_writes: got %0d expected 2", nw); end
      nvec++;
      if (done_cnt - dbase !== 0) begin
         nerr++; $display("FAIL midreset_done: got %0d pulses expected 0", done_cnt - dbase);
      end
      ref_mem.delete(30'h402);
      ref_mem.delete(30'h403);
      launch(1'b1, 30'h0, 30'h410, 3, 32'h0BAD_F00D);
      check_xfer("after_reset", 1'b1);
   endtask

   task automatic test_back_to_back();
      launch(1'b0, 30'h20, 30'h500, 2, 32'h0);
      check_xfer("b2b_first", 1'b0);
      launch(1'b1, 30'h0, 30'h600, 3, 32'h1111_2222);
      nvec++;
      if (done !== 1'b0) begin nerr++; $display("FAIL b2b_done_drop: got %b expected 0", done); end
      check_xfer("b2b_second", 1'b1);
   endtask

   task automatic test_random();
      logic [29:0] s, d;
      logic        fm;
      int          n;
      for (int t = 0; t < 12; t++) begin
         fm = 1'($urandom_range(0, 1));
         n  = $urandom_range(0, 7);
         s  = (t % 3 == 0) ? 30'h3FFFFFFF - 30'($urandom_range(0, 4)) : 30'($urandom);
         d  = s + 30'($urandom_range(0, 12));
         launch(fm, s, d, n, $urandom);
         check_xfer($sformatf("rand%0d", t), 1'b1);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_copy();
      test_fill();
      test_zero_count();
      test_wrap();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
